// File: rtl/tl_ul_responder.sv
// tl_ul_responder: TileLink-UL slave that serves Get/Put requests from a 64-bit memory
// and answers each accepted request with exactly one response after a programmable latency.
module tl_ul_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          DEPTH     = 256,
  parameter int          SRC_W     = 4,
  parameter int          LATENCY   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [2:0]       a_opcode,
  input  logic [2:0]       a_param,
  input  logic [2:0]       a_size,
  input  logic [SRC_W-1:0] a_source,
  input  logic [31:0]      a_address,
  input  logic [7:0]       a_mask,
  input  logic [63:0]      a_data,
  output logic             d_valid,
  input  logic             d_ready,
  output logic [2:0]       d_opcode,
  output logic [1:0]       d_param,
  output logic [2:0]       d_size,
  output logic [SRC_W-1:0] d_source,
  output logic [63:0]      d_data,
  output logic             d_error,
  output logic             busy
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t           r_state, w_next;
  logic [7:0]       r_cnt;
  logic [2:0]       r_op, r_size;
  logic [SRC_W-1:0] r_src;
  logic [63:0]      r_data;
  logic             r_err;
  logic [63:0]      r_mem [DEPTH];
  logic [31:0]      w_offset;
  logic [AW-1:0]    w_idx;
  logic             w_accept, w_get, w_put, w_err, w_unused;
  assign w_offset = a_address - BASE_ADDR;
  assign w_idx    = w_offset[AW+2:3];
  assign w_accept = a_valid && a_ready;
  assign w_get    = a_opcode == 3'd4;
  assign w_put    = a_opcode == 3'd0 || a_opcode == 3'd1;
  // unsigned compare makes addresses below BASE_ADDR wrap to huge offsets
  assign w_err    = w_offset >= 32'(DEPTH * 8) || a_size[2] || !(w_get || w_put) ||
                    |(a_address[2:0] & ~(3'b111 << a_size[1:0]));
  assign w_unused = ^{a_param, w_offset[2:0]};
  assign a_ready  = r_state == IDLE;
  assign d_valid  = r_state == RESP;
  assign busy     = r_state != IDLE;
  assign d_opcode = r_op;
  assign d_param  = 2'd0;
  assign d_size   = r_size;
  assign d_source = r_src;
  assign d_data   = r_data;
  assign d_error  = r_err;
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && w_accept) w_next = WAIT;
    else if (r_state == WAIT && r_cnt == 8'd0) w_next = RESP;
    else if (r_state == RESP && d_ready) w_next = IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 8'd0;
      r_op    <= 3'd0;
      r_size  <= 3'd0;
      r_src   <= '0;
      r_data  <= 64'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cnt  <= 8'(LATENCY);
        r_op   <= {2'b00, w_get};
        r_size <= a_size;
        r_src  <= a_source;
        r_err  <= w_err;
        r_data <= (w_get && !w_err) ? r_mem[w_idx] : 64'd0;
      end else if (r_state == WAIT && r_cnt != 8'd0) begin
        r_cnt <= r_cnt - 8'd1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (w_accept && w_put && !w_err && !reset)
      for (int i = 0; i < 8; i++)
        if (a_mask[i]) r_mem[w_idx][8*i +: 8] <= a_data[8*i +: 8];
  end
endmodule
